// File: rtl/nand_8bit.sv
// Bitwise NAND of two operands: combinational result plus an
// enable-loaded registered copy and an all-zero flag.
//
// Ports:
//   out        - combinational ~(a & b), live at all times
//   a, b       - operands
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset, priority over en
//   en         - load enable for out_q / all_zero_q
//   out_q      - registered NAND result (reset value all ones)
//   all_zero_q - registered flag, 1 when the loaded result is zero
module nand_8bit #(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] out_q,
  output logic             all_zero_q
);

  assign out = ~(a & b);

  // Reset value is the NAND of all-zero operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '1;
      all_zero_q <= 1'b0;
    end else if (en) begin
      out_q      <= out;
      all_zero_q <= (out == '0);
    end
  end

endmodule

// File: tb/tb_nand_8bit.sv
// Directed bench for nand_8bit: comb path without clock,
// then registered load, hold, reset priority and a random run.
module tb_nand_8bit;

  logic [7:0] out;
  logic [7:0] a;
  logic [7:0] b;
  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] out_q;
  logic       all_zero_q;
  logic       run_clk;

  int npass;
  int ntotal;

  logic [7:0] expq[$];
  string      tagq[$];

  nand_8bit #(.WIDTH(8)) dut (
    .out        (out),
    .a          (a),
    .b          (b),
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .out_q      (out_q),
    .all_zero_q (all_zero_q)
  );

  initial begin
    clk = 1'b0;
    wait (run_clk);
    forever #5 clk = ~clk;
  end

  task automatic push(input string tag, input logic [7:0] exp);
    tagq.push_back(tag);
    expq.push_back(exp);
  endtask

  task automatic check(input logic [7:0] obs);
    logic [7:0] exp;
    string      tag;
    ntotal++;
    if (expq.size() == 0) begin
      $error("FAIL scoreboard_empty obs=%h exp=none", obs);
      return;
    end
    exp = expq.pop_front();
    tag = tagq.pop_front();
    assert (obs === exp) npass++;
    else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] ta[8];
  logic [7:0] tb_v[8];
  logic [7:0] te[8];

  initial begin
    npass   = 0;
    ntotal  = 0;
    run_clk = 1'b0;
    rst     = 1'b0;
    en      = 1'b0;
    a       = 8'h00;
    b       = 8'h00;

    ta   = '{8'hFF, 8'h00, 8'hFF, 8'h55, 8'h82, 8'h84, 8'h88, 8'h90};
    tb_v = '{8'h4A, 8'hFF, 8'h81, 8'hAA, 8'h1E, 8'h40, 8'h85, 8'h97};
    te   = '{8'hB5, 8'hFF, 8'h7E, 8'hFF, 8'hFD, 8'hFF, 8'h7F, 8'h6F};

    // Combinational path with the clock stopped
    for (int i = 0; i < 8; i++) begin
      a = ta[i];
      b = tb_v[i];
      push($sformatf("comb_%0d", i), te[i]);
      #1;
      check(out);
    end

    run_clk = 1'b1;
    #2;

    // Reset
    rst = 1'b1;
    en  = 1'b0;
    push("rst_out_q", 8'hFF);
    push("rst_az", 8'h00);
    tick();
    check(out_q);
    check({7'd0, all_zero_q});

    // Load all-ones operands
    rst = 1'b0;
    en  = 1'b1;
    a   = 8'hFF;
    b   = 8'hFF;
    push("load_out_comb", 8'h00);
    #1;
    check(out);
    push("load_out_q", 8'h00);
    push("load_az", 8'h01);
    tick();
    check(out_q);
    check({7'd0, all_zero_q});

    // Hold across three edges
    en = 1'b0;
    a  = 8'hFF;
    b  = 8'h4A;
    push("hold_out_comb", 8'hB5);
    #1;
    check(out);
    for (int i = 0; i < 3; i++) begin
      push($sformatf("hold_out_q_%0d", i), 8'h00);
      push($sformatf("hold_az_%0d", i), 8'h01);
      tick();
      check(out_q);
      check({7'd0, all_zero_q});
    end

    // Reset has priority over enable
    rst = 1'b1;
    en  = 1'b1;
    a   = 8'hFF;
    b   = 8'hFF;
    push("prio_out_pre", 8'h00);
    #1;
    check(out);
    push("prio_out_q", 8'hFF);
    push("prio_az", 8'h00);
    push("prio_out_post", 8'h00);
    tick();
    check(out_q);
    check({7'd0, all_zero_q});
    check(out);

    // First edge after reset release loads immediately
    rst = 1'b0;
    en  = 1'b1;
    a   = 8'h82;
    b   = 8'h1E;
    push("resume_out_q", 8'hFD);
    push("resume_az", 8'h00);
    tick();
    check(out_q);
    check({7'd0, all_zero_q});

    // Random loads with a bench-side model
    for (int i = 0; i < 16; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [7:0] m;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i == 5) begin
        ra = 8'hFF;
        rb = 8'hFF;
      end
      m = 8'h00;
      for (int k = 0; k < 8; k++)
        m[k] = !(ra[k] && rb[k]);
      a = ra;
      b = rb;
      en = 1'b1;
      push($sformatf("rnd_out_q_%0d", i), m);
      push($sformatf("rnd_az_%0d", i), {7'd0, m == 8'h00});
      tick();
      check(out_q);
      check({7'd0, all_zero_q});
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
